// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter slice.
//   - shift op encodings (ISLL / ISRL / ISRA)
//   - default widths for data, shift amount and op code
//   - response-buffer state encoding
//   - op_legal(): true for the three shift encodings
package shift_arbiter_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_SH_W = 5;
  localparam int DEF_OP_W = 5;

  localparam logic [DEF_OP_W-1:0] ISLL = 5'h01;
  localparam logic [DEF_OP_W-1:0] ISRL = 5'h05;
  localparam logic [DEF_OP_W-1:0] ISRA = 5'h0D;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic op_legal(input logic [DEF_OP_W-1:0] op);
    return (op == ISLL) || (op == ISRL) || (op == ISRA);
  endfunction

endpackage

// File: rtl/shift.sv
// Combinational shifter shared by both requesters.
// Ports:
//   op     in  OP_W  instruction code
//   a      in  XLEN  operand
//   b      in  SH_W  shift amount
//   result out XLEN  shifted value (unknown codes fall through to SRA)
module shift
  import shift_arbiter_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int SH_W = DEF_SH_W,
  parameter int OP_W = DEF_OP_W
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [SH_W-1:0] b,
  output logic [XLEN-1:0] result
);

  logic signed [XLEN-1:0] a_s;
  assign a_s = a;

  always_comb begin
    result = a;
    case (op)
      ISLL:    result = a << b;
      ISRL:    result = a >> b;
      default: result = a_s >>> b;
    endcase
  end

endmodule

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   clk, rst   clock / synchronous active-high reset
//   v0, v1     requester valids
//   accept     a granted request was taken this cycle
//   grant      index of the requester that wins this cycle
// last_grant resets to 1 so requester 0 wins the first contested cycle.
module shift_arbiter_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic v0,
  input  logic v1,
  input  logic accept,
  output logic grant
);

  logic last_grant;

  // With a single valid requester it simply wins; ties go to the one
  // that did not win last time.
  assign grant = (v0 & v1) ? ~last_grant : v1;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates two requesters onto one shifter and holds the result in a
// one-entry response buffer with valid/ready handshake.
// Ports:
//   clk, rst                      clock / synchronous active-high reset
//   reqN_valid/ready/op/a/b       requester N channel (N = 0, 1)
//   resp_valid/ready              response handshake
//   resp_id                       requester index of the held result
//   resp_result                   shifted value (operand for illegal ops)
//   resp_err                      held op was not a shift encoding
//   busy                          result held and not drained this cycle
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int OP_W = DEF_OP_W,
  parameter int SH_W = DEF_SH_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [SH_W-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [SH_W-1:0] req1_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_err,
  output logic            busy
);

  state_t state_q, state_d;

  logic            can_accept;
  logic            grant;
  logic            accept_p0;
  logic [OP_W-1:0] op_p0;
  logic [XLEN-1:0] a_p0;
  logic [SH_W-1:0] b_p0;
  logic [XLEN-1:0] shifted_p0;
  logic            legal_p0;
  logic [XLEN-1:0] result_d_p0;

  logic [XLEN-1:0] result_p1;
  logic            id_p1;
  logic            err_p1;

  // ---- stage 0: arbitration and shift ----
  assign can_accept = (state_q == EMPTY) | ((state_q == FULL) & resp_ready);

  shift_arbiter_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .v0     (req0_valid),
    .v1     (req1_valid),
    .accept (accept_p0),
    .grant  (grant)
  );

  assign req0_ready = can_accept & (grant == 1'b0);
  assign req1_ready = can_accept & (grant == 1'b1);
  assign accept_p0  = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign op_p0 = grant ? req1_op : req0_op;
  assign a_p0  = grant ? req1_a  : req0_a;
  assign b_p0  = grant ? req1_b  : req0_b;

  shift #(.XLEN(XLEN), .SH_W(SH_W), .OP_W(OP_W)) u_shift (
    .op     (op_p0),
    .a      (a_p0),
    .b      (b_p0),
    .result (shifted_p0)
  );

  // Unknown codes pass the operand through instead of the shifter's SRA.
  assign legal_p0    = op_legal(op_p0);
  assign result_d_p0 = legal_p0 ? shifted_p0 : a_p0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept_p0) state_d = FULL;
      FULL:    if (resp_ready && !accept_p0) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // ---- stage 1: response buffer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      result_p1 <= '0;
      id_p1     <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_p0) begin
        result_p1 <= result_d_p0;
        id_p1     <= grant;
        err_p1    <= ~legal_p0;
      end
    end
  end

  assign resp_valid  = (state_q == FULL);
  assign resp_result = result_p1;
  assign resp_id     = id_p1;
  assign resp_err    = err_p1;
  assign busy        = (state_q == FULL) & ~resp_ready;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_op;
  logic [31:0] req0_a;
  logic [4:0]  req0_b;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_op;
  logic [31:0] req1_a;
  logic [4:0]  req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [31:0] resp_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_op = ISLL; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = ISLL; req1_a = 0; req1_b = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); resp_ready = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
    checks++; if (resp_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", resp_result); end
    checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %b want 0", resp_id); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", resp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    req0_valid = 1; req0_op = ISLL; req0_a = 32'h00000001; req0_b = 5'd31;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %b want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got %b want 0", req1_ready); end
    step();
    req0_valid = 0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", resp_valid); end
    checks++; if (resp_result !== 32'h80000000) begin errors++; $display("FAIL single_result got %h want 80000000", resp_result); end
    checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL single_id got %b want 0", resp_id); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", resp_err); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_res [2];
    exp_res[0] = 32'h08000000;
    exp_res[1] = 32'hF8000000;
    do_reset();
    req0_valid = 1; req0_op = ISRL; req0_a = 32'h80000000; req0_b = 5'd4;
    req1_valid = 1; req1_op = ISRA; req1_a = 32'h80000000; req1_b = 5'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req0_ready !== (i % 2 == 0)) begin errors++; $display("FAIL b2b_ready0[%0d] got %b want %b", i, req0_ready, (i % 2 == 0)); end
      checks++; if (req1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_ready1[%0d] got %b want %b", i, req1_ready, (i % 2 == 1)); end
      step();
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, resp_valid); end
      checks++; if (resp_result !== exp_res[i % 2]) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, resp_result, exp_res[i % 2]); end
      checks++; if (resp_id !== 1'(i % 2)) begin errors++; $display("FAIL b2b_id[%0d] got %b want %0d", i, resp_id, i % 2); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_stall();
    resp_ready = 1;
    req0_valid = 1; req0_op = ISLL; req0_a = 32'h1; req0_b = 5'd1;
    step();
    req0_valid = 0;
    resp_ready = 0;
    req1_valid = 1; req1_op = ISRL; req1_a = 32'h000000F0; req1_b = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL stall_ready1[%0d] got %b want 0", i, req1_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d] got %b want 1", i, busy); end
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, resp_valid); end
      checks++; if (resp_result !== 32'h2) begin errors++; $display("FAIL stall_result[%0d] got %h want 00000002", i, resp_result); end
      checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL stall_id[%0d] got %b want 0", i, resp_id); end
      step();
    end
    resp_ready = 1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready1 got %b want 1", req1_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_release_busy got %b want 0", busy); end
    step();
    req1_valid = 0;
    checks++; if (resp_result !== 32'h0000000F) begin errors++; $display("FAIL stall_new_result got %h want 0000000f", resp_result); end
    checks++; if (resp_id !== 1'b1) begin errors++; $display("FAIL stall_new_id got %b want 1", resp_id); end
    step();
  endtask

  task automatic test_illegal();
    req0_valid = 1; req0_op = 5'h1F; req0_a = 32'hDEADBEEF; req0_b = 5'd7;
    step();
    req0_valid = 0;
    checks++; if (resp_result !== 32'hDEADBEEF) begin errors++; $display("FAIL illegal_result got %h want deadbeef", resp_result); end
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b want 1", resp_err); end
    step();
  endtask

  task automatic test_zero_shift();
    logic [4:0] ops [3];
    ops[0] = ISLL; ops[1] = ISRL; ops[2] = ISRA;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_op = ops[i]; req0_a = 32'h12345678; req0_b = 5'd0;
      step();
      checks++; if (resp_result !== 32'h12345678) begin errors++; $display("FAIL zero_result[%0d] got %h want 12345678", i, resp_result); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL zero_err[%0d] got %b want 0", i, resp_err); end
    end
    req0_valid = 0;
    step();
  endtask

  task automatic test_reset_full();
    resp_ready = 0;
    req1_valid = 1; req1_op = ISLL; req1_a = 32'h3; req1_b = 5'd2;
    step();
    req1_valid = 0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rstfull_pre_valid got %b want 1", resp_valid); end
    rst = 1;
    step();
    rst = 0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstfull_valid got %b want 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstfull_busy got %b want 0", busy); end
    checks++; if (resp_result !== 32'h0) begin errors++; $display("FAIL rstfull_result got %h want 00000000", resp_result); end
    resp_ready = 1;
    req0_valid = 1; req0_op = ISLL; req0_a = 32'h1; req0_b = 5'd0;
    req1_valid = 1; req1_op = ISLL; req1_a = 32'h2; req1_b = 5'd0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rstfull_grant0 got %b want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rstfull_grant1 got %b want 0", req1_ready); end
    step();
    checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL rstfull_id got %b want 0", resp_id); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_zero_shift();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational `shift` instance between two requesters, e.g. the ALU issue path and the address/immediate-generation path.
- Arbitrates round-robin, registers the result, and presents it on a valid/ready response channel with a requester tag.
- One-entry output buffer. Supports back-to-back throughput of one shift per cycle while the consumer stays ready.

Parameters:
- XLEN, 32, data width of operand and result.
- OP_W, 5, width of the instruction code (`ISLL/`ISRL/`ISRA encodings from the shared defines).
- SH_W, 5, shift-amount width, equal to log2(XLEN).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  OP_W  requester 0 instruction code.
- req0_a  in  XLEN  requester 0 operand.
- req0_b  in  SH_W  requester 0 shift amount.
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1.
- resp_valid  out  1  registered result available.
- resp_ready  in  1  consumer takes the result.
- resp_id  out  1  requester index of the held result.
- resp_result  out  XLEN  shifted value.
- resp_err  out  1  held op was not `ISLL/`ISRL/`ISRA.
- busy  out  1  resp_valid held and not being drained this cycle.

Behaviour:
- Reset: all outputs 0 (resp_valid=0, resp_id=0, resp_result=0, resp_err=0, busy=0); last_grant=1, so requester 0 wins the first contested cycle. Reset takes priority over every other event.
- FSM states:
  - EMPTY: no result held.
  - FULL: resp_valid=1.
- can_accept = (state==EMPTY) | (state==FULL & resp_ready).
- Arbitration, combinational in the same cycle:
  - If only one requester is valid, grant it.
  - If both are valid, grant !last_grant.
  - Update last_grant only on an actual accept.
- reqN_ready = can_accept & grant==N. Never assert both readies in one cycle.
- Accept = reqN_valid & reqN_ready. On accept, the selected op/a/b drive the shift instance; result, id and err are registered at the edge.
- Latency: accept at edge N, resp_valid=1 after edge N, one cycle.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + resp_ready + accept -> FULL, with the new result and no bubble.
  - FULL + resp_ready + no accept -> EMPTY.
  - FULL + !resp_ready -> FULL. resp_result, resp_id and resp_err hold stable; no accept.
- Illegal op: resp_result = req_a unchanged, resp_err=1. The shift instance's SRA default is not used.
- Shift amount 0 returns the operand unchanged for all ops.
- `ISRA is arithmetic: sign-fills from bit XLEN-1.
- Requester protocol: valid, op, a and b must stay stable until ready. The block does not latch un-accepted requests.
- Fairness: a continuously valid requester is accepted within 2 accept opportunities.
- rst asserted while FULL: the held result is discarded and resp_valid=0 after that edge; the consumer never sees it.
- busy = (state==FULL) & !resp_ready.

Decomposition:
- Shared package/defines:
  - `ISLL/`ISRL/`ISRA op encodings (already shared).
  - XLEN, SH_W.
  - State encoding: EMPTY=1'b0, FULL=1'b1.
- Sub-module: reuse the existing `shift` module as the single datapath instance.
- Optional small sub-module rr_arb2: 2-way round-robin grant with a last_grant register.

Test Plan:
- After reset, req0 `ISLL a=0x00000001 b=31 -> req0_ready=1 in the same cycle; next cycle resp_valid=1, resp_result=0x80000000, resp_id=0, resp_err=0.
- Both valid every cycle with resp_ready=1: req0 `ISRL a=0x80000000 b=4, req1 `ISRA a=0x80000000 b=4 -> grants alternate 0,1,0,1; results alternate 0x08000000 (id 0) and 0xF8000000 (id 1) with no bubbles.
- resp_ready=0 for 3 cycles while FULL, req1 valid -> req1_ready=0, resp_result/resp_id stable, busy=1. Then resp_ready=1 -> req1 accepted in the same cycle; new result 1 cycle later.
- req0 op=5'h1F (illegal) a=0xDEADBEEF b=7 -> resp_result=0xDEADBEEF, resp_err=1.
- Any op with b=0, a=0x12345678 -> resp_result=0x12345678, resp_err=0.
- rst pulsed for one cycle while FULL with resp_ready=0 -> resp_valid=0 after that edge. Next contested cycle grants req0 first.
